tty_ctrl: RTL and testbench

//  Memory-mapped console controller for the 0xE I/O region of the cpu32 data bus.

---
 rtl/tty_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/tty_ctrl.sv | 124 ++++++++++++
 tb/tb_tty_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tty_pkg.sv
// Shared definitions for the console controller: register offsets, register bit
// positions and the drain FSM encoding.
package tty_pkg;
  localparam logic [1:0] TTY_DATA   = 2'd0;
  localparam logic [1:0] TTY_STATUS = 2'd1;
  localparam logic [1:0] TTY_CTRL   = 2'd2;
  localparam logic [1:0] TTY_RSVD   = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  localparam int CT_EN      = 0;
  localparam int CT_IE      = 1;
  localparam int CT_CLR_OVF = 4;
  localparam int CT_FLUSH   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } drain_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with push/pop/flush; a pushed entry is never visible at the
// head in the same cycle it is written.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Flush overrides both sides; full/empty are the pre-edge values.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tty_ctrl.sv
// Memory-mapped console controller: buffers CPU byte stores and feeds them one at a
// time to the uart transmitter, with status/control registers and an interrupt.
module tty_ctrl
  import tty_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        irq
);
  logic                wr_data;
  logic                wr_ctrl;
  logic                flush;
  logic                en;
  logic                ie;
  logic                overflow;
  logic                hi_wait;
  logic [7:0]          head;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  drain_state_t        state;
  logic                unused_wdata;

  assign unused_wdata = ^{wdata[31:6], wdata[3:2]};

  assign wr_data = cs & we & (addr == TTY_DATA);
  assign wr_ctrl = cs & we & (addr == TTY_CTRL);
  assign flush   = wr_ctrl & wdata[CT_FLUSH];

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (state == LOAD),
    .flush (flush),
    .din   (wdata[7:0]),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b1;
      ie       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en <= wdata[CT_EN];
        ie <= wdata[CT_IE];
        if (wdata[CT_CLR_OVF]) overflow <= 1'b0;
      end
      if (wr_data & full & ~flush) overflow <= 1'b1;
    end
  end

  // Drain FSM: tx_start is high exactly while in LOAD; WAIT_HI gives up after two
  // cycles so a uart that never acknowledges cannot stall the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      hi_wait  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (en && !empty && !tx_busy) begin
            state    <= LOAD;
            tx_start <= 1'b1;
            tx_data  <= head;
          end
        end
        LOAD: begin
          state   <= WAIT_HI;
          hi_wait <= 1'b0;
        end
        WAIT_HI: begin
          if (tx_busy)      state   <= WAIT_LO;
          else if (hi_wait) state   <= IDLE;
          else              hi_wait <= 1'b1;
        end
        WAIT_LO: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        TTY_STATUS: begin
          rdata[ST_EMPTY]                  = empty;
          rdata[ST_FULL]                   = full;
          rdata[ST_BUSY]                   = tx_busy;
          rdata[ST_OVF]                    = overflow;
          rdata[ST_COUNT +: DEPTH_LOG2+1]  = count;
        end
        TTY_CTRL: begin
          rdata[CT_EN] = en;
          rdata[CT_IE] = ie;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign irq = ie & (empty | overflow);
endmodule

// File: tb/tb_tty_ctrl.sv
// Bench for tty_ctrl: register table, uart model with a transmit scoreboard, and
// hand-written sequences for overflow, flush, lost handshake and reset.
module tb_tty_ctrl;
  import tty_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        irq;

  int n_vec = 0;
  int n_fail = 0;
  int n_start = 0;
  int cyc = 0;
  int last_start = 0;
  bit have_last = 0;
  logic [7:0] exp_q[$];
  int gaps[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tty_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .irq      (irq)
  );

  // uart model: busy for 10 cycles after each tx_start (or never, when busy_en=0)
  logic       busy_en;
  logic [3:0] ucnt;
  always @(posedge clk or posedge reset) begin
    if (reset)                    ucnt <= 4'd0;
    else if (tx_start && busy_en) ucnt <= 4'd10;
    else if (ucnt != 4'd0)        ucnt <= ucnt - 4'd1;
  end
  assign tx_busy = (ucnt != 4'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: every tx_start pops the oldest expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_start) begin
        n_start++;
        if (have_last) gaps.push_back(cyc - last_start);
        last_start = cyc;
        have_last = 1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_tx: got tx_data 0x%02h, expected no transmission", tx_data);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr(TTY_DATA, {24'h0, b});
    exp_q.push_back(b);
  endtask

  task automatic wait_starts(input string name, input int target, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (n_start >= target) break;
    end
    check(name, n_start, target);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < max_cyc; i++) begin
      rd(TTY_STATUS, s);
      if (s == 32'h1 && exp_q.size() == 0) break;
    end
    check({name, "_status"}, s, 32'h1);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;
  localparam int NV = 10;
  vec_t tbl[NV];

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int          n0;

    tbl[0] = '{1'b0, TTY_STATUS, 32'h0,         32'h0000_0001, 1'b0};
    tbl[1] = '{1'b0, TTY_CTRL,   32'h0,         32'h0000_0001, 1'b0};
    tbl[2] = '{1'b0, TTY_DATA,   32'h0,         32'h0000_0000, 1'b0};
    tbl[3] = '{1'b0, TTY_RSVD,   32'h0,         32'h0000_0000, 1'b0};
    tbl[4] = '{1'b1, TTY_CTRL,   32'h0000_0003, 32'h0,         1'b1};
    tbl[5] = '{1'b0, TTY_CTRL,   32'h0,         32'h0000_0003, 1'b1};
    tbl[6] = '{1'b1, TTY_RSVD,   32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[7] = '{1'b0, TTY_CTRL,   32'h0,         32'h0000_0003, 1'b1};
    tbl[8] = '{1'b1, TTY_CTRL,   32'h0000_0031, 32'h0,         1'b0};
    tbl[9] = '{1'b0, TTY_CTRL,   32'h0,         32'h0000_0001, 1'b0};

    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0; busy_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_start", {31'b0, tx_start}, 32'h0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h0);
    reset = 1'b0;
    addr = TTY_CTRL;
    #1;
    check("rdata_cs0", rdata, 32'h0);

    // register table
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].d);
      end else begin
        rd(tbl[i].a, r);
        check($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rd);
      end
      check($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end

    // 1: 'H','i' back-to-back
    gaps.delete(); have_last = 0; n0 = n_start;
    push_byte(8'h48);
    push_byte(8'h69);
    wait_starts("hi_starts", n0 + 2, 100);
    check("hi_gap", (gaps.size() > 0) ? gaps[0] : 0, 13);
    wait_drain("hi_drain", 100);

    // 2: 17 bytes into a stopped FIFO
    wr(TTY_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) push_byte(b);
      else        wr(TTY_DATA, {24'h0, b});
    end
    rd(TTY_STATUS, r);
    check("ovf_status", r, 32'h0000_100A);
    check("ovf_irq_ie0", {31'b0, irq}, 32'h0);
    wr(TTY_CTRL, 32'h02);
    check("ovf_irq_ie1", {31'b0, irq}, 32'h1);
    wr(TTY_CTRL, 32'h12);
    check("ovf_clr_irq", {31'b0, irq}, 32'h0);
    rd(TTY_STATUS, r);
    check("ovf_clr_status", r, 32'h0000_1002);

    // 3: push into a full FIFO in the LOAD (pop) cycle
    wr(TTY_CTRL, 32'h01);
    @(posedge clk);
    @(negedge clk);
    check("full_pop_load", {31'b0, tx_start}, 32'h1);
    cs = 1'b1; we = 1'b1; addr = TTY_DATA; wdata = 32'hEE;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; wdata = '0;
    rd(TTY_STATUS, r);
    check("full_pop_status", r, 32'h0000_0F0C);
    wr(TTY_CTRL, 32'h11);
    wait_drain("full_drain", 400);

    // 4: flush during WAIT_LO
    wr(TTY_CTRL, 32'h0);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
    n0 = n_start;
    wr(TTY_CTRL, 32'h01);
    wait_starts("flush_first", n0 + 1, 50);
    repeat (4) @(posedge clk);
    exp_q.delete();
    wr(TTY_CTRL, 32'h21);
    repeat (20) @(negedge clk);
    check("flush_starts", n_start, n0 + 1);
    rd(TTY_STATUS, r);
    check("flush_status", r, 32'h0000_0001);
    push_byte(8'h5A);
    wait_drain("flush_after", 50);
    check("flush_after_starts", n_start, n0 + 2);

    // 5: uart never acknowledges
    busy_en = 1'b0;
    wr(TTY_CTRL, 32'h0);
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    gaps.delete(); have_last = 0; n0 = n_start;
    wr(TTY_CTRL, 32'h01);
    wait_starts("nohs_starts", n0 + 4, 100);
    check("nohs_gap_count", gaps.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("nohs_gap%0d", i), (gaps.size() > i) ? gaps[i] : 0, 4);
    wait_drain("nohs_drain", 50);
    busy_en = 1'b1;

    // 6: reset during WAIT_HI with 5 bytes queued
    wr(TTY_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    n0 = n_start;
    wr(TTY_CTRL, 32'h01);
    wait_starts("rst_first", n0 + 1, 50);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_tx_start", {31'b0, tx_start}, 32'h0);
    rd(TTY_STATUS, r);
    check("rst_status", r, 32'h0000_0001);
    rd(TTY_CTRL, r);
    check("rst_ctrl", r, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_tx", n_start, n0 + 1);
    rd(TTY_STATUS, r);
    check("rst_idle_status", r, 32'h0000_0001);

    // 7: reset in the LOAD cycle drops tx_start without waiting for a clock edge
    n0 = n_start;
    push_byte(8'h77);
    wait_starts("rst_load_start", n0 + 1, 50);
    reset = 1'b1;
    #1;
    check("rst_load_tx_start", {31'b0, tx_start}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
